// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: FSM state encodings and master IDs shared by the memory bus arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'b001,
        ARB_ISSUE = 3'b010,
        ARB_RESP  = 3'b100
    } arb_state_t;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_DMA = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin CPU/DMA arbiter in front of a single synchronous-read memory port
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic [DATA_W-1:0]   dma_wdata,
    input  logic [DATA_W/8-1:0] dma_be,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [DATA_W-1:0]   dma_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t          state;
    logic                owner;
    logic                last_owner;
    logic                any_req;
    logic                win;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_be;

    // On a tie the master that did not own the last access wins
    always_comb begin
        any_req   = cpu_req | dma_req;
        win       = (cpu_req && dma_req) ? ~last_owner : (dma_req ? MASTER_DMA : MASTER_CPU);
        sel_we    = (win == MASTER_DMA) ? dma_we    : cpu_we;
        sel_addr  = (win == MASTER_DMA) ? dma_addr  : cpu_addr;
        sel_wdata = (win == MASTER_DMA) ? dma_wdata : cpu_wdata;
        sel_be    = (win == MASTER_DMA) ? dma_be    : cpu_be;
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            owner      <= MASTER_CPU;
            last_owner <= MASTER_DMA;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            cpu_gnt    <= 1'b0;
            dma_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_gnt    <= 1'b0;
            dma_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            if (state == ARB_ISSUE) begin
                // mem_we is dropped with mem_en; its old value decides whether RESP returns data
                mem_en     <= 1'b0;
                mem_we     <= 1'b0;
                cpu_rvalid <= !mem_we && (owner == MASTER_CPU);
                dma_rvalid <= !mem_we && (owner == MASTER_DMA);
                last_owner <= owner;
                state      <= ARB_RESP;
            end else if (any_req) begin
                mem_en    <= 1'b1;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_be    <= sel_be;
                owner     <= win;
                cpu_gnt   <= (win == MASTER_CPU);
                dma_gnt   <= (win == MASTER_DMA);
                state     <= ARB_ISSUE;
            end else begin
                state <= ARB_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench; stimulus queues expected grants/read data, a monitor checks them
module tb_mem_bus_arbiter;

    localparam logic C = 1'b0;
    localparam logic D = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [3:0]  dma_be = '0;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [31:0] ram [0:63];

    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int at;} req_t;
    typedef struct {logic m; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int gap; int lat;} gexp_t;
    typedef struct {logic m; logic [31:0] d;} rexp_t;

    req_t  cpu_q[$], dma_q[$];
    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t ge;
    rexp_t re;
    int tests = 0, fails = 0, cyc = 0, last_g = 0;
    int pc[2], gc[2];

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_be(dma_be),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM; word i preloads to 0x1000_0000+i, word 4 (0x10) to 0xDEADBEEF
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h1000_0000 + 32'(i);
            ram[4] <= 32'hDEADBEEF;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[7:2]];
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic rq_add(input logic m, input logic we, input logic [31:0] a, input logic [31:0] w,
                          input logic [3:0] be, input int at);
        req_t r;
        r = '{we, a, w, be, at};
        if (m) dma_q.push_back(r);
        else cpu_q.push_back(r);
    endtask

    task automatic rd(input logic m, input logic [31:0] a, input int at, input int gap, input int lat,
                      input logic [31:0] d);
        rq_add(m, 1'b0, a, 32'd0, 4'hF, at);
        gq.push_back('{m, 1'b0, a, 32'd0, 4'hF, gap, lat});
        rq.push_back('{m, d});
    endtask

    task automatic wr(input logic m, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                      input int at, input int gap, input int lat);
        rq_add(m, 1'b1, a, w, be, at);
        gq.push_back('{m, 1'b1, a, w, be, gap, lat});
    endtask

    // Plays both masters' request queues, holding each req until its gnt is seen
    task automatic run();
        req_t r;
        bit cb = 0;
        bit db = 0;
        int n;
        for (n = 0; n < 100; n++) begin
            if (n > 0) begin
                @(negedge clk);
                #1;
            end
            if (cb && cpu_gnt) begin cb = 0; cpu_req = 1'b0; end
            if (db && dma_gnt) begin db = 0; dma_req = 1'b0; end
            if (!cb && cpu_q.size() > 0 && cpu_q[0].at <= n) begin
                r = cpu_q.pop_front();
                {cpu_we, cpu_addr, cpu_wdata, cpu_be} = {r.we, r.addr, r.wdata, r.be};
                cpu_req = 1'b1; cb = 1; pc[0] = cyc;
            end
            if (!db && dma_q.size() > 0 && dma_q[0].at <= n) begin
                r = dma_q.pop_front();
                {dma_we, dma_addr, dma_wdata, dma_be} = {r.we, r.addr, r.wdata, r.be};
                dma_req = 1'b1; db = 1; pc[1] = cyc;
            end
            if (!cb && !db && cpu_q.size() == 0 && dma_q.size() == 0) break;
        end
        chk("run_budget", 32'(n < 100), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
        chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (cpu_gnt || dma_gnt) begin
            if (gq.size() == 0) begin
                chk("unexpected_gnt", 32'({cpu_gnt, dma_gnt}), 32'd0);
            end else begin
                ge = gq.pop_front();
                chk("gnt_who", 32'({cpu_gnt, dma_gnt}), ge.m ? 32'd1 : 32'd2);
                chk("gnt_mem_en", 32'(mem_en), 32'd1);
                chk("gnt_mem_we", 32'(mem_we), 32'(ge.we));
                chk("gnt_mem_addr", mem_addr, ge.addr);
                chk("gnt_mem_be", 32'(mem_be), 32'(ge.be));
                if (ge.we) chk("gnt_mem_wdata", mem_wdata, ge.wdata);
                if (ge.gap != 0) chk("gnt_gap", 32'(cyc - last_g), 32'(ge.gap));
                if (ge.lat != 0) chk("gnt_latency", 32'(cyc - pc[ge.m]), 32'(ge.lat));
                gc[ge.m] = cyc;
            end
            last_g = cyc;
        end else begin
            chk("idle_mem_en", 32'(mem_en), 32'd0);
        end
        if (cpu_rvalid || dma_rvalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
            end else begin
                re = rq.pop_front();
                chk("rvalid_who", 32'({cpu_rvalid, dma_rvalid}), re.m ? 32'd1 : 32'd2);
                chk("rdata", re.m ? dma_rdata : cpu_rdata, re.d);
                chk("rvalid_latency", 32'(cyc - gc[re.m]), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'({mem_en, mem_we, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_mem_be", 32'(mem_be), 32'd0);
        #1 reset = 1'b1;
        // Reset asserted in the middle of a CPU read's ISSUE cycle
        @(negedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_be = 4'hF;
        @(posedge clk);
        #1;
        chk("mid_issue_mem_en", 32'(mem_en), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_mem_en", 32'(mem_en), 32'd0);
        chk("async_reset_gnt", 32'({cpu_gnt, dma_gnt}), 32'd0);
        chk("async_reset_mem_addr", mem_addr, 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        // First tie after reset goes to the CPU
        rd(C, 32'h10, 0, 0, 1, 32'hDEADBEEF);
        rd(D, 32'h10, 0, 2, 3, 32'hDEADBEEF);
        run();
        // DMA partial write, then CPU reads it back
        wr(D, 32'h40, 32'h12345678, 4'b0011, 0, 0, 1);
        rd(C, 32'h40, 4, 0, 1, 32'h1000_5678);
        run();
        // CPU back-to-back reads: one grant every 2 cycles
        rd(C, 32'h20, 0, 0, 1, 32'h1000_0008);
        rd(C, 32'h24, 0, 2, 2, 32'h1000_0009);
        rd(C, 32'h28, 0, 2, 2, 32'h1000_000A);
        run();
        // DMA arrives in CPU RESP while CPU re-requests: DMA wins, CPU follows
        rd(C, 32'h30, 0, 0, 1, 32'h1000_000C);
        rd(D, 32'h38, 2, 2, 1, 32'h1000_000E);
        rd(C, 32'h34, 0, 2, 4, 32'h1000_000D);
        run();
        // Continuous contention; CPU owned last, so DMA leads and grants alternate
        for (int i = 0; i < 4; i++) begin
            rd(D, 32'h50 + 32'(4 * i), 0, (i > 0) ? 2 : 0, (i > 0) ? 4 : 1, 32'h1000_0014 + 32'(i));
            rd(C, 32'(4 * i), 0, 2, (i > 0) ? 4 : 3, 32'h1000_0000 + 32'(i));
        end
        run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single synchronous-read memory port between the multicycle CPU and the DMA/boot-loader master. It sits between the CPU's memory interface and the unified instruction/data RAM, and serialises accesses with round-robin fairness. Each master sees a req/gnt handshake with a read-valid strobe, and stalls its own sequencing until the grant arrives.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- cpu_be  in  DATA_W/8  byte enables
- cpu_gnt  out  1  one-cycle pulse: access issued to memory
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid (reads only)
- cpu_rdata  out  DATA_W  read data
- dma_req, dma_we, dma_addr, dma_wdata, dma_be, dma_gnt, dma_rvalid, dma_rdata: identical set for the DMA master
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the memory samples mem_en

## Operation
- Handshake rules:
  - A master raises req with stable we/addr/wdata/be, and holds them until it sees gnt.
  - Dropping req before gnt is a protocol violation. Once a request is latched, the access completes regardless.
- FSM states: IDLE, ISSUE, RESP. Encoding is one-hot, 3 bits.
- IDLE / RESP (arbitration points):
  - If any req is high, pick a winner.
  - Latch the winner's payload into the registered mem_* outputs, set owner, and go to ISSUE.
  - Otherwise go to (or stay in) IDLE.
- Winner selection:
  - Only one request high: that master wins.
  - Both high: the master not equal to last_owner wins.
- ISSUE:
  - mem_en = 1. Pulse gnt of the owner.
  - last_owner <= owner. Go to RESP.
- RESP:
  - mem_en = 0.
  - If the latched access was a read, pulse rvalid of the owner. rdata of both masters = mem_rdata; it is only meaningful while rvalid is high.
  - Arbitrate as in IDLE in the same cycle.
- Writes produce gnt only, never rvalid.
- Reset values:
  - state = IDLE, last_owner = DMA, so the CPU wins the first tie.
  - mem_en = mem_we = 0; mem_addr, mem_wdata, mem_be = 0.
  - All gnt and rvalid outputs = 0.
- Reset asserted mid-access: all outputs return to reset values at once (asynchronous). The in-flight access is dropped with no gnt or rvalid, and the master must re-request.
- A request from the master that was just granted, presented in RESP, competes normally. With the other master requesting, it loses the tie.

## Timing
- Request seen at edge T (in IDLE):
  - ISSUE occupies cycle T+1: mem_en and gnt are high.
  - Memory samples at the end of T+1.
  - RESP occupies cycle T+2: mem_rdata and rvalid are valid.
- Request latency is 1 cycle to gnt and 2 cycles to rvalid.
- Sustained throughput is one access per 2 cycles (ISSUE/RESP alternating).
- Under continuous contention, grants strictly alternate CPU, DMA, CPU, … and each master waits at most 2 extra cycles.
- All outputs are registered except rdata, which passes mem_rdata through.

## Structure
- Arbiter_Define.v, alongside the existing Define headers, holds:
  - state encodings ARB_IDLE, ARB_ISSUE, ARB_RESP
  - master IDs MASTER_CPU = 1'b0, MASTER_DMA = 1'b1
- Single module with no sub-module. The winner pick is a few lines of combinational logic.
- The CPU control FSM treats !cpu_gnt as a stall in its fetch and memory-access states. The integration change belongs to the CPU, not to this block.

## Test plan
- Reset with reset = 0 mid-ISSUE of a CPU read → on the same cycle mem_en = 0, cpu_gnt = 0, state IDLE. After release, the first CPU-vs-DMA tie goes to the CPU.
- CPU read of addr 0x0000_0010 (memory holds 0xDEADBEEF) → mem_en = 1 one cycle after req; cpu_gnt pulses the same cycle; cpu_rvalid = 1 with cpu_rdata = 0xDEADBEEF one cycle later.
- DMA write of addr 0x40, wdata 0x12345678, be 4'b0011 → mem_we = 1, mem_be = 0011 during ISSUE, dma_gnt pulses, no dma_rvalid. A subsequent CPU read of 0x40 returns 0x????5678 in its low half.
- Both req held high for 8 accesses → grant order CPU, DMA, CPU, DMA, …; gnt pulses 2 cycles apart.
- CPU alone issues back-to-back reads → one gnt every 2 cycles, no idle cycles between them.
- DMA request arrives during a CPU RESP cycle while the CPU also re-requests → DMA wins, and the CPU is granted in the following arbitration.
